pwm_sched: RTL and testbench
============================

// Module: pwm_sched
// PURPOSE
//  Multi-channel PWM scheduler. One shared period counter drives NCH compare
//  channels; each channel has its own rise and fall points. Software writes
//  period and compare values through a valid/ready port into pending
//  registers. Pending values are committed only at a period boundary, so no
//  glitched cycle is produced. Sits between the control/register logic and
//  the pad/LED outputs; it generalises the fixed single-channel PWM generator.
// PARAMETERS
//  NCH     4    number of PWM channels (1..16)
//  CNT_W   16   width of the counter, PERIOD, RISE and FALL
// PORTS
//  clk         in   1          single clock, rising edge
//  rstn        in   1          reset, synchronous, active-low
//  wr_valid    in   1          write request
//  wr_ready    out  1          write accepted when wr_valid&&wr_ready
//  wr_addr     in   6          register address (map below)
//  wr_data     in   CNT_W      write data
//  pwm_out     out  NCH        PWM outputs, registered
//  running     out  1          1 in RUN or STOPPING
//  period_end  out  1          only with PWM_SCHED_IRQ_EN: 1-cycle pulse at wrap
// BEHAVIOUR
//  Address map:
//   0 = CTRL (bit0 run); 1 = PERIOD; 2+2i = RISE_i; 3+2i = FALL_i.
//   Other addresses: write is accepted and dropped.
//  Write rules:
//   - CTRL takes effect immediately.
//   - PERIOD, RISE and FALL writes go to pending copies and set upd_pend.
//   - A later write to the same register overwrites its pending copy.
//  wr_ready: 1 except in the commit cycle (cnt==active PERIOD while RUN or
//   STOPPING). In that cycle it is 0, so a commit and a write never collide.
//  Reset (rstn==0 at posedge):
//   - state=STOP, cnt=0, pwm_out=0, running=0, period_end=0, upd_pend=0.
//   - Active and pending PERIOD=15; all RISE=4; all FALL=7.
//  State machine: STOP, RUN, STOPPING.
//   - STOP: cnt held at 0, pwm_out=0. A CTRL write with run=1 moves to RUN
//     next cycle, cnt=0, and pending is committed to active if upd_pend.
//   - RUN: cnt increments each cycle. At cnt==PERIOD, cnt->0, commit if
//     upd_pend, then clear upd_pend. A CTRL write with run=0 moves to
//     STOPPING.
//   - STOPPING: counts like RUN. A CTRL write with run=1 returns to RUN.
//     At cnt==PERIOD: go to STOP, pwm_out->0, pending is NOT committed.
//  Counter: the period length is PERIOD+1 cycles. A PERIOD of 0 is treated
//   as 1 (minimum 2-cycle period). The counter never exceeds active PERIOD.
//  Channel i, registered, 1-cycle latency from the compare:
//   - In the wrap cycle (cnt==PERIOD), the next value is 0; every period
//     starts low.
//   - Else if cnt==FALL_i, the next value is 0 (fall has priority over rise).
//   - Else if cnt==RISE_i, the next value is 1.
//   - Else the output holds.
//   - RISE_i>=PERIOD means the channel is never high.
//   - FALL_i>PERIOD means the channel falls at the wrap.
//  Simultaneous events:
//   - A CTRL write in the wrap cycle is blocked, because wr_ready=0.
//   - Reset mid-period drops every pending value immediately.
// CONFIGURATION
//  PWM_SCHED_IRQ_EN defined:
//   period_end=1 for one cycle, registered, the cycle after every wrap in
//   RUN or STOPPING. Reset value 0.
//  PWM_SCHED_IRQ_EN undefined:
//   period_end port and its logic are absent; all other behaviour is
//   identical.
// STRUCTURE
//  Shared package/include pwm_sched_pkg:
//   - Address constants ADDR_CTRL=0, ADDR_PERIOD=1, ADDR_CH_BASE=2.
//   - State encoding ST_STOP, ST_RUN, ST_STOPPING.
//   - Reset defaults RST_PERIOD=15, RST_RISE=4, RST_FALL=7.
//  Sub-module pwm_sched_chan, one instance per channel:
//   - Holds the pending and active RISE/FALL registers and the output flop.
//   - Inputs are cnt, wrap, commit and write strobes.
//  The top level holds the FSM, the counter, PERIOD and address decode.
// TESTING
//  1. Reset, write CTRL=1 -> ch0 high at cnt 5..7 each 16-cycle period;
//     running=1.
//  2. In RUN, write RISE_1=2, FALL_1=10 mid-period -> no change until the
//     next period. Then ch1 is high at cycles 3..10. Holding wr_valid across
//     the wrap shows wr_ready=0 for 1 cycle.
//  3. PERIOD=0 then run -> 2-cycle period. RISE=FALL=1 -> output stays 0.
//  4. CTRL=0 mid-period -> STOPPING, finishes the period, then STOP with
//     pwm_out=0 and running=0. CTRL=1 during STOPPING -> stays RUN, no gap.
//  5. rstn=0 for 1 cycle mid-period with pending writes -> all outputs 0.
//     Defaults restored; pending writes are never applied.
//  6. PWM_SCHED_IRQ_EN: period_end pulses once per PERIOD+1 cycles, and
//     never in STOP.

Source files
------------

// File: rtl/pwm_sched_pkg.sv
// pwm_sched_pkg: shared constants and types for the multi-channel PWM scheduler.
//   - Register address map (CTRL, PERIOD, per-channel RISE/FALL pairs).
//   - Scheduler state encoding.
//   - Reset defaults for PERIOD, RISE and FALL.
//   - chan_addr(): address of RISE_i (is_fall=0) or FALL_i (is_fall=1).
package pwm_sched_pkg;

    localparam logic [5:0] ADDR_CTRL    = 6'd0;
    localparam logic [5:0] ADDR_PERIOD  = 6'd1;
    localparam logic [5:0] ADDR_CH_BASE = 6'd2;

    localparam int RST_PERIOD = 15;
    localparam int RST_RISE   = 4;
    localparam int RST_FALL   = 7;

    typedef enum logic [1:0] {
        ST_STOP     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } state_t;

    function automatic logic [5:0] chan_addr(input int ch, input logic is_fall);
        return ADDR_CH_BASE + 6'(2 * ch) + {5'b0, is_fall};
    endfunction

endpackage

// File: rtl/pwm_sched_if.sv
// pwm_sched_if: register write port of the PWM scheduler.
//   wr_valid  request from the master
//   wr_ready  slave can accept this cycle
//   wr_addr   6-bit register address
//   wr_data   CNT_W-bit write data
// Handshake: a write transfers on every rising clock edge where
// wr_valid && wr_ready; the master holds addr/data stable while wr_valid is
// high and not yet accepted, and wr_ready never depends on wr_valid.
interface pwm_sched_if #(
    parameter int CNT_W = 16
);
    logic             wr_valid;
    logic             wr_ready;
    logic [5:0]       wr_addr;
    logic [CNT_W-1:0] wr_data;

    modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/pwm_sched_chan.sv
// pwm_sched_chan: one PWM compare channel.
// Holds pending and active RISE/FALL values and the registered output.
// Ports:
//   clk, rstn   clock, synchronous active-low reset
//   cnt         shared period counter
//   active      scheduler is in RUN or STOPPING
//   wrap        counter is at the active PERIOD this cycle
//   commit      copy pending RISE/FALL into active
//   rise_we     write wr_data into pending RISE
//   fall_we     write wr_data into pending FALL
//   wr_data     write data
//   pwm         registered channel output
module pwm_sched_chan
    import pwm_sched_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [CNT_W-1:0] cnt,
    input  logic             active,
    input  logic             wrap,
    input  logic             commit,
    input  logic             rise_we,
    input  logic             fall_we,
    input  logic [CNT_W-1:0] wr_data,
    output logic             pwm
);

    logic [CNT_W-1:0] rise_pend;
    logic [CNT_W-1:0] fall_pend;
    logic [CNT_W-1:0] rise_act;
    logic [CNT_W-1:0] fall_act;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rise_pend <= CNT_W'(RST_RISE);
            fall_pend <= CNT_W'(RST_FALL);
            rise_act  <= CNT_W'(RST_RISE);
            fall_act  <= CNT_W'(RST_FALL);
            pwm       <= 1'b0;
        end else begin
            if (rise_we) rise_pend <= wr_data;
            if (fall_we) fall_pend <= wr_data;
            if (commit) begin
                rise_act <= rise_pend;
                fall_act <= fall_pend;
            end
            // Wrap forces low so every period starts low; fall beats rise.
            if (!active || wrap)       pwm <= 1'b0;
            else if (cnt == fall_act)  pwm <= 1'b0;
            else if (cnt == rise_act)  pwm <= 1'b1;
        end
    end

endmodule

// File: rtl/pwm_sched.sv
// pwm_sched: multi-channel PWM scheduler with period-boundary commit.
// One shared counter runs 0..PERIOD; NCH channels compare it against their
// own RISE/FALL points. PERIOD/RISE/FALL writes land in pending copies and
// are committed at a period wrap (RUN) or when starting from STOP.
// Optional feature macro: PWM_SCHED_IRQ_EN adds the period_end pulse output.
// Ports:
//   clk, rstn   clock, synchronous active-low reset
//   wr          register write port (slave side of pwm_sched_if)
//   pwm_out     NCH registered PWM outputs
//   running     1 in RUN or STOPPING
//   state       current scheduler state, for observation
//   period_end  (PWM_SCHED_IRQ_EN only) 1-cycle pulse after every wrap
module pwm_sched
    import pwm_sched_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int CNT_W = 16
) (
    input  logic           clk,
    input  logic           rstn,
    pwm_sched_if.slave     wr,
    output logic [NCH-1:0] pwm_out,
    output logic           running,
    output state_t         state
`ifdef PWM_SCHED_IRQ_EN
    ,
    output logic           period_end
`endif
);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] period_pend;
    logic             upd_pend;
    logic             wrap;
    logic             fire;
    logic             ctrl_we;
    logic             period_we;
    logic             commit;
    logic [NCH-1:0]   rise_we;
    logic [NCH-1:0]   fall_we;
    logic             pend_we;

    // Wrap is the commit cycle; blocking writes here keeps commit and
    // write apart.
    assign wrap        = (state_q != ST_STOP) && (cnt == period);
    assign wr.wr_ready = !wrap;
    assign fire        = wr.wr_valid && wr.wr_ready;
    assign ctrl_we     = fire && (wr.wr_addr == ADDR_CTRL);
    assign period_we   = fire && (wr.wr_addr == ADDR_PERIOD);
    assign pend_we     = period_we || (|rise_we) || (|fall_we);
    assign commit      = upd_pend &&
                         (((state_q == ST_STOP) && ctrl_we && wr.wr_data[0]) ||
                          ((state_q == ST_RUN) && wrap));
    assign running     = (state_q != ST_STOP);
    assign state       = state_q;

    always_ff @(posedge clk) begin
        if (!rstn) state_q <= ST_STOP;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_STOP:     if (ctrl_we && wr.wr_data[0]) state_d = ST_RUN;
            ST_RUN:      if (ctrl_we && !wr.wr_data[0]) state_d = ST_STOPPING;
            ST_STOPPING: begin
                if (wrap)                            state_d = ST_STOP;
                else if (ctrl_we && wr.wr_data[0])   state_d = ST_RUN;
            end
            default:                                 state_d = ST_STOP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt         <= '0;
            period      <= CNT_W'(RST_PERIOD);
            period_pend <= CNT_W'(RST_PERIOD);
            upd_pend    <= 1'b0;
        end else begin
            if ((state_q == ST_STOP) || wrap) cnt <= '0;
            else                              cnt <= cnt + CNT_W'(1);
            // PERIOD 0 is stored as 1 so the counter always has two states.
            if (period_we)
                period_pend <= (wr.wr_data == '0) ? CNT_W'(1) : wr.wr_data;
            if (commit) period <= period_pend;
            // A RUN wrap clears upd_pend whether or not anything committed;
            // a STOPPING wrap leaves pending values waiting for the next start.
            if (pend_we)                                   upd_pend <= 1'b1;
            else if (commit || ((state_q == ST_RUN) && wrap)) upd_pend <= 1'b0;
        end
    end

`ifdef PWM_SCHED_IRQ_EN
    always_ff @(posedge clk) begin
        if (!rstn) period_end <= 1'b0;
        else       period_end <= wrap;
    end
`endif

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign rise_we[i] = fire && (wr.wr_addr == chan_addr(i, 1'b0));
        assign fall_we[i] = fire && (wr.wr_addr == chan_addr(i, 1'b1));

        pwm_sched_chan #(.CNT_W(CNT_W)) u_chan (
            .clk     (clk),
            .rstn    (rstn),
            .cnt     (cnt),
            .active  (running),
            .wrap    (wrap),
            .commit  (commit),
            .rise_we (rise_we[i]),
            .fall_we (fall_we[i]),
            .wr_data (wr.wr_data),
            .pwm     (pwm_out[i])
        );
    end

endmodule

// File: tb/tb_pwm_sched.sv
`timescale 1ns/1ps
module tb_pwm_sched;
    import pwm_sched_pkg::*;

    localparam int NCH   = 4;
    localparam int CNT_W = 16;
    localparam int EW    = NCH + 3;

    // ---------------- clock / reset ----------------
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    pwm_sched_if #(.CNT_W(CNT_W)) bus ();
    logic [NCH-1:0] pwm_out;
    logic           running;
    state_t         dut_state;
    logic           period_end;

    pwm_sched #(.NCH(NCH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .wr         (bus),
        .pwm_out    (pwm_out),
        .running    (running),
        .state      (dut_state)
`ifdef PWM_SCHED_IRQ_EN
        ,
        .period_end (period_end)
`endif
    );
`ifndef PWM_SCHED_IRQ_EN
    assign period_end = 1'b0;
`endif

    // ---------------- reference model ----------------
    // Mode 0 = stopped, 1 = running, 2 = finishing the current period.
    // Outputs are derived from the position in the period with a closed-form
    // rule, not by replaying compare events.
    int m_mode, m_phase, m_p, m_pp;
    int m_r[NCH], m_f[NCH], m_rp[NCH], m_fp[NCH];
    bit m_upd, m_pe, m_wrap, m_fire;
    int m_a, m_d;
    logic [EW-1:0] m_exp;
    logic [EW-1:0] exp_q[$];

    function automatic bit high_at(int c, int p, int r, int f);
        return (r < p) && (r != f) && (c > r) && ((f < r) || (c <= f));
    endfunction

    function automatic void model_commit();
        m_p = m_pp;
        for (int i = 0; i < NCH; i++) begin
            m_r[i] = m_rp[i];
            m_f[i] = m_fp[i];
        end
    endfunction

    always @(posedge clk) begin
        if (!rstn) begin
            m_mode = 0; m_phase = 0; m_p = 15; m_pp = 15; m_upd = 0; m_pe = 0;
            for (int i = 0; i < NCH; i++) begin
                m_r[i] = 4; m_f[i] = 7; m_rp[i] = 4; m_fp[i] = 7;
            end
        end else begin
            m_wrap = (m_mode != 0) && (m_phase == m_p);
            m_fire = bus.wr_valid && !m_wrap;
            m_pe   = m_wrap;
            m_phase = (m_mode == 0 || m_wrap) ? 0 : m_phase + 1;
            if (m_fire) begin
                m_a = int'(bus.wr_addr);
                m_d = int'(bus.wr_data);
                if (m_a == 0) begin
                    if (m_mode == 0 && m_d[0]) begin
                        m_mode = 1;
                        if (m_upd) begin model_commit(); m_upd = 0; end
                    end else if (m_mode == 1 && !m_d[0]) m_mode = 2;
                    else if (m_mode == 2 && m_d[0])      m_mode = 1;
                end else if (m_a == 1) begin
                    m_pp = (m_d == 0) ? 1 : m_d;
                    m_upd = 1;
                end else if (m_a >= 2 && m_a < 2 + 2 * NCH) begin
                    if (m_a % 2 == 0) m_rp[(m_a - 2) / 2] = m_d;
                    else              m_fp[(m_a - 2) / 2] = m_d;
                    m_upd = 1;
                end
            end
            if (m_wrap) begin
                if (m_mode == 1) begin
                    if (m_upd) model_commit();
                    m_upd = 0;
                end else if (m_mode == 2) m_mode = 0;
            end
        end
        for (int i = 0; i < NCH; i++)
            m_exp[i] = (m_mode != 0) && high_at(m_phase, m_p, m_r[i], m_f[i]);
        m_exp[NCH]     = (m_mode != 0);
`ifdef PWM_SCHED_IRQ_EN
        m_exp[NCH + 1] = m_pe;
`else
        m_exp[NCH + 1] = 1'b0;
`endif
        m_exp[NCH + 2] = !((m_mode != 0) && (m_phase == m_p));
        exp_q.push_back(m_exp);
    end

    // ---------------- scoreboard / monitor ----------------
    int total = 0;
    int bad   = 0;
    logic [EW-1:0] mon_exp, mon_act;
    string dir_tag;
    int dir_act, dir_exp;
    int dir_seq = 0;
    int dir_done = 0;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_act = {bus.wr_ready, period_end, running, pwm_out};
            total++;
            if (mon_act !== mon_exp) begin
                bad++;
                $display("FAIL cycle_out t=%0t act=%b exp=%b (ready,period_end,running,pwm)",
                         $time, mon_act, mon_exp);
            end
        end
        if (dir_seq != dir_done) begin
            dir_done = dir_seq;
            total++;
            if (dir_act != dir_exp) begin
                bad++;
                $display("FAIL %s act=%0d exp=%0d", dir_tag, dir_act, dir_exp);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic post(input string tag, input int act, input int exp);
        dir_tag = tag; dir_act = act; dir_exp = exp; dir_seq++;
        @(negedge clk); #1;
    endtask

    task automatic wr(input int addr, input int data, output int stalls);
        int n;
        @(negedge clk);
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 6'(addr);
        bus.wr_data  = CNT_W'(data);
        stalls = 0;
        n = 0;
        #1;
        while (!bus.wr_ready && n < 20) begin
            stalls++; n++;
            @(negedge clk); #1;
        end
        if (n == 20) post("write_timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
        bus.wr_valid = 1'b0;
    endtask

    task automatic wait_phase(input int target);
        int n;
        n = 0;
        @(negedge clk); #1;
        while (!(m_mode != 0 && m_phase == target) && n < 200) begin
            n++;
            @(negedge clk); #1;
        end
        if (n == 200) post("wait_phase_timeout", 0, 1);
    endtask

    task automatic measure(input int ch, input int ncyc, output int highs);
        highs = 0;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk); #1;
            if (pwm_out[ch]) highs++;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk); rstn = 1'b0;
        @(negedge clk); rstn = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int st, h, n, op, a, d;
        bus.wr_valid = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;

        // Start with defaults: ch0 high 3 cycles of every 16.
        wr(0, 1, st);
        repeat (2) @(negedge clk);
        measure(0, 16, h);
        post("t1_ch0_high", h, 3);

        // Mid-period RISE_1 write, then FALL_1 held across a wrap.
        wait_phase(5);
        wr(4, 2, st);
        wait_phase(14);
        wr(5, 10, st);
        post("t2_wrap_stall", st, 1);
        repeat (40) @(negedge clk);
        measure(1, 16, h);
        post("t2_ch1_high", h, 8);

        // Stop mid-period, resume while finishing, then stop for real.
        wait_phase(3);
        wr(0, 0, st);
        repeat (3) @(negedge clk);
        wr(0, 1, st);
        measure(1, 16, h);
        post("t4_resume_high", h, 8);
        wr(0, 0, st);
        repeat (20) @(negedge clk);
        post("t4_running", int'(running), 0);

        // PERIOD=0 gives a 2-cycle period; RISE=FALL=1 never goes high.
        wr(1, 0, st);
        wr(2, 1, st);
        wr(3, 1, st);
        wr(0, 1, st);
        n = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); #1;
            if (!bus.wr_ready) n++;
        end
        post("t3_ready_lows", n, 5);
        measure(0, 10, h);
        post("t3_ch0_high", h, 0);

        // Pending writes then reset: defaults come back, pending lost.
        wr(1, 9, st);
        wr(6, 3, st);
        pulse_reset();
        wr(0, 1, st);
        repeat (2) @(negedge clk);
        measure(0, 16, h);
        post("t5_ch0_high", h, 3);
        measure(2, 16, h);
        post("t5_ch2_high", h, 3);

        // Randomized traffic checked cycle by cycle against the model.
        for (int k = 0; k < 300; k++) begin
            op = int'($urandom_range(0, 99));
            if (op < 3) begin
                pulse_reset();
            end else if (op < 75) begin
                a = int'($urandom_range(0, 2 + 2 * NCH));
                if (a == 2 + 2 * NCH) a = int'($urandom_range(2 + 2 * NCH, 63));
                if (a == 0)      d = ($urandom_range(0, 9) < 7) ? 1 : 0;
                else if (a == 1) d = int'($urandom_range(0, 12));
                else             d = int'($urandom_range(0, 14));
                wr(a, d, st);
            end else begin
                repeat (int'($urandom_range(1, 12))) @(negedge clk);
            end
        end

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
